arith_sched_ctrl: RTL and testbench
===================================

ARITH_SCHED_CTRL -- requirements
Module: arith_sched_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 8, operand/result width in bits.
REQ-002 SHALL have port i_clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_req_valid  input  2  per-channel request valid (bit0 = ch0, bit1 = ch1).
REQ-005 SHALL have ports o_req_ready  output  2  per-channel accept; at most one bit high.
REQ-006 SHALL have ports i_req_op0 / i_req_op1  input  2 each  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
REQ-007 SHALL have ports i_req_a0, i_req_b0, i_req_a1, i_req_b1  input  DATA_W each  operands a and b per channel.
REQ-008 SHALL have port o_rsp_valid  output  1  response valid.
REQ-009 SHALL have port i_rsp_ready  input  1  response consumed.
REQ-010 SHALL have port o_rsp_result  output  DATA_W  operation result.
REQ-011 SHALL have port o_rsp_id  output  1  channel that issued the request.
REQ-012 SHALL have port o_rsp_err  output  1  divide-by-zero flag.
REQ-013 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, DIV, RESP.
REQ-015 o_req_ready SHALL be non-zero only in IDLE, driven combinationally to the granted channel.
REQ-016 Grant in IDLE: one channel valid -> that channel; both valid -> channel named by 1-bit priority pointer.
REQ-017 Priority pointer SHALL point to the non-granted channel after every accept (round-robin).
REQ-018 On accept (valid & ready), op, a, b and channel id SHALL be registered; next state DIV if op=DIV and b!=0, else EXEC.
REQ-019 EXEC SHALL last one cycle: ADD = (a+b) mod 2^DATA_W, SUB = (a-b) mod 2^DATA_W, MUL = low DATA_W bits of a*b; next state RESP.
REQ-020 DIV with b=0 SHALL take the EXEC path: result all-ones, o_rsp_err=1.
REQ-021 DIV with b!=0 SHALL run an unsigned restoring divide, one quotient bit per cycle, exactly DATA_W cycles in DIV, then RESP; result = floor(a/b), err=0.
REQ-022 Latency: accept on edge k -> o_rsp_valid high after edge k+1 (EXEC ops) or edge k+DATA_W (non-zero DIV).
REQ-023 In RESP, o_rsp_valid SHALL be 1 and result/id/err SHALL hold stable until i_rsp_ready=1; that edge returns to IDLE.
REQ-024 No request SHALL be accepted in the cycle the response is consumed; earliest next accept is the following IDLE cycle.
REQ-025 o_rsp_result, o_rsp_id, o_rsp_err SHALL be registered; they are don't-care-free: held at last value outside RESP.
REQ-026 Requests deasserted before accept SHALL be ignored; i_req_* changes after accept SHALL not affect the operation in flight.

Reset
REQ-027 i_rst_n low SHALL immediately force state IDLE, priority pointer ch0, o_rsp_valid 0, o_rsp_result 0, o_rsp_id 0, o_rsp_err 0, o_busy 0, divider state 0.
REQ-028 Reset asserted mid-DIV or mid-RESP SHALL abort the operation with no response issued after release.

Structure
REQ-029 Shared package SHALL hold opcode constants, FSM state encoding and DATA_W default.
REQ-030 Divider SHALL be sub-module arith_div_iter (start, a, b -> done, quotient after DATA_W cycles, same clock/reset).

Verification
REQ-031 ch0 ADD a=200 b=100 -> accept, o_rsp_valid after next edge, result 44, id 0, err 0.
REQ-032 After reset both channels valid, ch0 SUB 5-7, ch1 MUL 20*13 -> ch0 first (result 254), then ch1 (result 4, id 1).
REQ-033 ch1 DIV 200/7 -> o_busy for DATA_W+1 cycles, result 28, err 0, rsp_valid after edge k+8.
REQ-034 ch0 DIV 5/0 -> result 255, err 1, latency as ADD.
REQ-035 i_rsp_ready low 5 cycles in RESP with both channels valid -> result/id/err stable, o_req_ready stays 0.
REQ-036 i_rst_n pulsed low during DIV cycle 3 -> outputs zero immediately, no response after release, next grant to ch0.

Source files
------------

// File: rtl/arith_sched_ctrl_pkg.sv
// Shared definitions for the two-channel arithmetic scheduler:
// opcode and FSM state encodings plus the default datapath width.
package arith_sched_ctrl_pkg;

   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DIV,
      RESP
   } state_e;

endpackage

// File: rtl/arith_div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The first bit is resolved on the start edge so the quotient is ready DATA_W edges after start.
module arith_div_iter #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_done,
   output logic [DATA_W-1:0] o_quotient
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

   logic [DATA_W:0]   rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] dvs_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;

   logic [DATA_W:0]   src_rem;
   logic [DATA_W-1:0] src_quo;
   logic [DATA_W-1:0] src_dvs;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   trial;
   logic [DATA_W:0]   rem_n;
   logic [DATA_W-1:0] quo_n;

   // The dividend shifts out of quo while quotient bits shift in behind it.
   always_comb begin
      src_rem = i_start ? '0  : rem_q;
      src_quo = i_start ? i_a : quo_q;
      src_dvs = i_start ? i_b : dvs_q;
      shifted = {src_rem[DATA_W-1:0], src_quo[DATA_W-1]};
      trial   = shifted - {1'b0, src_dvs};
      if (!trial[DATA_W]) begin
         rem_n = trial;
         quo_n = {src_quo[DATA_W-2:0], 1'b1};
      end else begin
         rem_n = shifted;
         quo_n = {src_quo[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (i_start) begin
         rem_q  <= rem_n;
         quo_q  <= quo_n;
         dvs_q  <= i_b;
         cnt_q  <= CNT_W'(1);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (cnt_q == LAST) begin
            busy_q <= 1'b0;
         end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign o_done     = busy_q && (cnt_q == LAST);
   assign o_quotient = quo_q;

endmodule

// File: rtl/arith_sched_ctrl.sv
// Two-channel round-robin request scheduler in front of a single ALU
// (add/sub/mul single cycle, iterative divide) with a held response port.
module arith_sched_ctrl
   import arith_sched_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_req_valid,
   output logic [1:0]        o_req_ready,
   input  logic [1:0]        i_req_op0,
   input  logic [1:0]        i_req_op1,
   input  logic [DATA_W-1:0] i_req_a0,
   input  logic [DATA_W-1:0] i_req_b0,
   input  logic [DATA_W-1:0] i_req_a1,
   input  logic [DATA_W-1:0] i_req_b1,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_result,
   output logic              o_rsp_id,
   output logic              o_rsp_err,
   output logic              o_busy
);

   state_e            state_q, state_d;
   logic              ptr_q;
   op_e               op_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic              id_q;

   logic [1:0]        grant;
   logic              accept;
   logic              grant_id;
   op_e               req_op;
   logic [DATA_W-1:0] req_a, req_b;
   logic              div_start, div_done;
   logic [DATA_W-1:0] div_quo;
   logic [DATA_W-1:0] exec_res;
   logic              exec_err;

   // Only IDLE grants; ptr names the channel favoured when both request.
   always_comb begin
      grant = '0;
      if (state_q == IDLE) begin
         case (i_req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = '0;
         endcase
      end
   end

   assign o_req_ready = grant;
   assign accept      = |grant;
   assign grant_id    = grant[1];
   assign req_op      = op_e'(grant_id ? i_req_op1 : i_req_op0);
   assign req_a       = grant_id ? i_req_a1 : i_req_a0;
   assign req_b       = grant_id ? i_req_b1 : i_req_b0;
   assign div_start   = accept && (req_op == OP_DIV) && (req_b != '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = div_start ? DIV : EXEC;
         EXEC:    state_d = RESP;
         DIV:     if (div_done) state_d = RESP;
         RESP:    if (i_rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A divide reaching EXEC can only be the divide-by-zero case.
   always_comb begin
      exec_res = '0;
      exec_err = 1'b0;
      case (op_q)
         OP_ADD:  exec_res = a_q + b_q;
         OP_SUB:  exec_res = a_q - b_q;
         OP_MUL:  exec_res = a_q * b_q;
         default: begin
            exec_res = '1;
            exec_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         op_q         <= OP_ADD;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         o_rsp_result <= '0;
         o_rsp_id     <= 1'b0;
         o_rsp_err    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ptr_q <= ~grant_id;
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            id_q  <= grant_id;
         end
         if (state_q == EXEC) begin
            o_rsp_result <= exec_res;
            o_rsp_err    <= exec_err;
            o_rsp_id     <= id_q;
         end else if ((state_q == DIV) && div_done) begin
            o_rsp_result <= div_quo;
            o_rsp_err    <= 1'b0;
            o_rsp_id     <= id_q;
         end
      end
   end

   assign o_rsp_valid = (state_q == RESP);
   assign o_busy      = (state_q != IDLE);

   arith_div_iter #(
      .DATA_W(DATA_W)
   ) u_div (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (div_start),
      .i_a        (req_a),
      .i_b        (req_b),
      .o_done     (div_done),
      .o_quotient (div_quo)
   );

endmodule

// File: tb/tb_arith_sched_ctrl.sv
// Scoreboard bench for arith_sched_ctrl: accepts push model results into a queue,
// a negedge monitor pops and compares each presented response.
module tb_arith_sched_ctrl;

   localparam int unsigned W   = 8;
   localparam int unsigned MOD = 1 << W;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b1;
   logic [1:0]    i_req_valid = '0;
   logic [1:0]    o_req_ready;
   logic [1:0]    i_req_op0 = '0, i_req_op1 = '0;
   logic [W-1:0]  i_req_a0 = '0, i_req_b0 = '0, i_req_a1 = '0, i_req_b1 = '0;
   logic          o_rsp_valid;
   logic          i_rsp_ready = 1'b1;
   logic [W-1:0]  o_rsp_result;
   logic          o_rsp_id;
   logic          o_rsp_err;
   logic          o_busy;

   arith_sched_ctrl #(.DATA_W(W)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_op0    (i_req_op0),
      .i_req_op1    (i_req_op1),
      .i_req_a0     (i_req_a0),
      .i_req_b0     (i_req_b0),
      .i_req_a1     (i_req_a1),
      .i_req_b1     (i_req_b1),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_result (o_rsp_result),
      .o_rsp_id     (o_rsp_id),
      .o_rsp_err    (o_rsp_err),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc++;

   typedef struct {
      int unsigned res;
      int unsigned id;
      int unsigned err;
      int          due;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   bit   ptr_m = 1'b0;
   int   resp_cnt = 0;
   int   busy_cnt = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_event(input string name);
      total++;
      $display("FAIL %s: event occurred where none was allowed (t=%0t)", name, $time);
   endtask

   function automatic int unsigned model_grant(input logic [1:0] v, input bit ptr);
      if (v == 2'b01) return 1;
      if (v == 2'b10) return 2;
      if (v == 2'b11) return ptr ? 2 : 1;
      return 0;
   endfunction

   function automatic exp_t model_op(input int unsigned op, input int unsigned a,
                                     input int unsigned b, input int unsigned id, input int now);
      exp_t e;
      e.id  = id;
      e.err = 0;
      e.lat = 1;
      case (op)
         0: e.res = (a + b) % MOD;
         1: e.res = (a + MOD - b) % MOD;
         2: e.res = (a * b) % MOD;
         default: begin
            if (b == 0) begin
               e.res = MOD - 1;
               e.err = 1;
            end else begin
               e.res = a / b;
               e.lat = W;
            end
         end
      endcase
      e.due = now + 1 + e.lat;
      return e;
   endfunction

   // Monitor and scoreboard
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         sb.delete();
         ptr_m    = 1'b0;
         resp_cnt = 0;
         busy_cnt = 0;
      end else begin
         if (o_busy) busy_cnt++;
         if (!o_busy) check("grant", o_req_ready, model_grant(i_req_valid, ptr_m));
         else         check("ready_when_busy", o_req_ready, 0);
         if (o_rsp_valid) begin
            if (sb.size() == 0) begin
               fail_event("spurious_rsp");
            end else begin
               resp_cnt++;
               if (resp_cnt == 1) check("latency", cyc, sb[0].due);
               check("rsp_result", o_rsp_result, sb[0].res);
               check("rsp_id", o_rsp_id, sb[0].id);
               check("rsp_err", o_rsp_err, sb[0].err);
               if (i_rsp_ready) begin
                  check("busy_len", busy_cnt, sb[0].lat + resp_cnt);
                  void'(sb.pop_front());
                  resp_cnt = 0;
                  busy_cnt = 0;
               end
            end
         end
         if (|(o_req_ready & i_req_valid)) begin
            if (o_req_ready[1])
               sb.push_back(model_op(i_req_op1, i_req_a1, i_req_b1, 1, cyc));
            else
               sb.push_back(model_op(i_req_op0, i_req_a0, i_req_b0, 0, cyc));
            ptr_m    = ~o_req_ready[1];
            busy_cnt = 0;
         end
      end
   end

   task automatic do_reset();
      @(posedge i_clk);
      #3 i_rst_n = 1'b0;
      #1;
      check("rst_valid", o_rsp_valid, 0);
      check("rst_result", o_rsp_result, 0);
      check("rst_id", o_rsp_id, 0);
      check("rst_err", o_rsp_err, 0);
      check("rst_busy", o_busy, 0);
      @(posedge i_clk);
      #3 i_rst_n = 1'b1;
   endtask

   task automatic set_req(input logic [1:0] v,
                          input int unsigned op0, input int unsigned a0, input int unsigned b0,
                          input int unsigned op1, input int unsigned a1, input int unsigned b1);
      i_req_valid = v;
      i_req_op0 = 2'(op0); i_req_a0 = W'(a0); i_req_b0 = W'(b0);
      i_req_op1 = 2'(op1); i_req_a1 = W'(a1); i_req_b1 = W'(b1);
   endtask

   task automatic wait_accept(input string tag);
      for (int i = 0; i < 60; i++) begin
         @(negedge i_clk);
         if (|(o_req_ready & i_req_valid)) return;
      end
      fail_event({"timeout_accept_", tag});
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         if (!o_busy && sb.size() == 0) return;
      end
      fail_event({"timeout_idle_", tag});
   endtask

   task automatic wait_rsp(input string tag);
      for (int i = 0; i < 60; i++) begin
         @(negedge i_clk);
         if (o_rsp_valid) return;
      end
      fail_event({"timeout_rsp_", tag});
   endtask

   task automatic single(input string tag, input logic [1:0] v,
                         input int unsigned op, input int unsigned a, input int unsigned b);
      @(posedge i_clk); #1;
      set_req(v, op, a, b, op, a, b);
      wait_accept(tag);
      @(posedge i_clk); #1;
      i_req_valid = '0;
      wait_idle(tag);
   endtask

   initial begin
      #2;
      do_reset();

      // ch0 ADD 200+100
      single("add", 2'b01, 0, 200, 100);
      check("add_held_result", o_rsp_result, 44);
      check("add_held_id", o_rsp_id, 0);
      check("add_held_err", o_rsp_err, 0);

      // both channels after reset: ch0 SUB first, then ch1 MUL
      do_reset();
      @(posedge i_clk); #1;
      set_req(2'b11, 1, 5, 7, 2, 20, 13);
      wait_accept("both_first");
      check("both_first_grant", o_req_ready, 1);
      @(posedge i_clk); #1;
      i_req_valid = 2'b10;
      wait_accept("both_second");
      @(posedge i_clk); #1;
      i_req_valid = '0;
      wait_idle("both");
      check("mul_held_result", o_rsp_result, 4);
      check("mul_held_id", o_rsp_id, 1);

      single("div", 2'b10, 3, 200, 7);
      check("div_held_result", o_rsp_result, 28);
      check("div_held_err", o_rsp_err, 0);

      single("div0", 2'b01, 3, 5, 0);
      check("div0_held_result", o_rsp_result, 255);
      check("div0_held_err", o_rsp_err, 1);

      // response back-pressure with both channels requesting
      @(posedge i_clk); #1;
      i_rsp_ready = 1'b0;
      set_req(2'b11, 0, 1, 2, 0, 3, 4);
      wait_accept("hold");
      wait_rsp("hold");
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("hold_ready", o_req_ready, 0);
      end
      @(posedge i_clk); #1;
      i_req_valid = '0;
      i_rsp_ready = 1'b1;
      wait_idle("hold");

      // reset during the third divide cycle
      @(posedge i_clk); #1;
      set_req(2'b10, 0, 0, 0, 3, 250, 3);
      wait_accept("abort");
      @(posedge i_clk); #1;
      i_req_valid = '0;
      @(posedge i_clk);
      #1 check("abort_busy_before", o_busy, 1);
      do_reset();
      for (int i = 0; i < 12; i++) @(negedge i_clk);
      @(posedge i_clk); #1;
      set_req(2'b11, 0, 9, 9, 0, 8, 8);
      @(negedge i_clk);
      check("grant_after_rst", o_req_ready, 1);
      @(posedge i_clk); #1;
      i_req_valid = '0;
      wait_idle("after_rst");

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         @(posedge i_clk); #1;
         i_req_valid = 2'($urandom_range(0, 3));
         i_req_op0   = 2'($urandom_range(0, 3));
         i_req_op1   = 2'($urandom_range(0, 3));
         i_req_a0    = W'($urandom_range(0, MOD - 1));
         i_req_a1    = W'($urandom_range(0, MOD - 1));
         i_req_b0    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, MOD - 1));
         i_req_b1    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, MOD - 1));
         i_rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge i_clk); #1;
      i_req_valid = '0;
      i_rsp_ready = 1'b1;
      wait_idle("random");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
